board_perm_gen: RTL
===================

# board_perm_gen

Parametrised board generator for the tile puzzle. Produces an N-piece board as a permutation of piece codes 0..N-1, either from a player-selected permutation index or from an internal LFSR. Builds the permutation sequentially (Fisher–Yates, one swap per cycle) under a req/ready/done handshake. Sits between the board-select input logic and the game controller, and is only active while `game_status` is CHOSE_BOARD.

## Interface
- `N`, default 4: piece count; legal range 2..8.
- `W`, default 3: piece-code width; 2^W ≥ N required.
- `IW`, default 5: index width; 2^IW ≥ N! required.
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk_d` input 1: the single clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `game_status` input 2: 00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED.
- `num` input IW: permutation index, used in index mode.
- `random` input 1: one-cycle pulse that toggles the generation mode.
- `req` input 1: generation request, accepted only when `ready`=1.
- `ready` output 1: high when idle and `game_status`=CHOSE_BOARD.
- `done` output 1: one-cycle pulse when a new board is written to `out`.
- `err` output 1: one-cycle pulse when an index-mode request is rejected.
- `rand_mode` output 1: current mode; 0 = index, 1 = random.
- `out` output N*W: board; piece a[0] in the MSBs (`out[N*W-1 -: W]`), a[N-1] in the LSBs.

## Operation
- Identity board: a[i]=i. For N=4, W=3 this is 12'h053 (000_001_010_011).
- States:
  - IDLE: accepts requests.
  - RUN: performs swaps; registers are `k` and `idx_r`.
  - DONE: publishes the result.
- Request acceptance: a request is accepted when `req`=1, state=IDLE and `game_status`=CHOSE_BOARD.
  - The mode is sampled at acceptance.
  - Index mode with `num` ≥ N!: `err` pulses, state stays IDLE, `out` unchanged.
  - Otherwise: `work` ← identity, `k` ← N, `idx_r` ← `num`, go to RUN.
- RUN, each cycle:
  - Compute j:
    - Index mode: j = `idx_r` mod k, and `idx_r` ← `idx_r` / k.
    - Random mode: j = `lfsr[7:0]` mod k. The small modulo bias is accepted.
  - Swap a[k-1] with a[k-1-j]; j=0 is a no-op.
  - `k` ← k-1. If k was 2, go to DONE.
- DONE: `out` ← `work`, pulse `done`, return to IDLE.
- Index 0 yields the identity. Indices 0..N!-1 map bijectively onto all N! permutations.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle from reset, regardless of state.
  - Never reaches zero.
- `random` pulse: toggles `rand_mode` in any state. An in-flight run keeps the mode sampled at its acceptance.
- When `game_status` ≠ CHOSE_BOARD:
  - `out` is forced to identity every cycle.
  - Any RUN/DONE aborts to IDLE with no `done`.
  - Requests are ignored.
- `req` while not ready is dropped; there is no queueing.
- The divide and modulo use only k ∈ 2..N, so small constant-case logic suffices.

## Timing
- Reset values (asserted asynchronously on `rst_n`=0):
  - `out` = identity, state IDLE.
  - `done`=0, `err`=0, `rand_mode`=0.
  - `ready`=1 provided `game_status`=CHOSE_BOARD.
  - `lfsr`=SEED.
- Acceptance at clock edge E0:
  - RUN swaps occur at edges E1..E(N-1).
  - `out` updates and `done`=1 at edge EN; latency is N cycles (4 for the defaults).
- `ready` is 0 from E1 through EN and returns to 1 after EN. The next request is accepted at E(N+1) at the earliest.
- `err` is high for exactly the one cycle following the rejecting edge.
- Abort: if `game_status` leaves CHOSE_BOARD before EN, `out` = identity from the next edge and `done` never fires.
- Reset mid-RUN: immediate return to reset values; the partial board is discarded.
- `out` is stable between `done` pulses while in CHOSE_BOARD.

## Test plan
- Reset, `game_status`=00, index mode, `num`=5, `req` pulse:
  - Required: `done` exactly 4 cycles later; `out`=12'h0CA (0,3,1,2).
  - Required: `ready` low for 4 cycles.
- `num`=23 -> `out`=12'h298 (1,2,3,0). `num`=0 -> `out`=12'h053.
- `num`=24 -> `err` pulse on the next cycle; no `done`; `out` unchanged; `ready` stays 1.
- `random` pulse, then three `req`s:
  - Required: `rand_mode`=1.
  - Required: each output is a valid permutation (distinct codes 0..3).
  - Required: results match a reference model of the LFSR from SEED.
- Run started, then `game_status`←01 at E2:
  - Required: no `done`; `out`=12'h053 from E3.
  - Required: extra `req` pulses while busy are ignored.
- `rst_n` low mid-RUN:
  - Required: outputs return to reset values immediately; LFSR = SEED.
- All 24 indices swept: 24 distinct boards.

Source files
------------

// File: rtl/board_perm_gen.sv
// board_perm_gen: builds an N-piece tile-puzzle board as a permutation of
// piece codes 0..N-1, either from a permutation index or from an LFSR,
// one Fisher-Yates swap per cycle under a req/ready/done handshake.
module board_perm_gen #(
  parameter int          N    = 4,
  parameter int          W    = 3,
  parameter int          IW   = 5,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic           clk_d,
  input  logic           rst_n,
  input  logic [1:0]     game_status,
  input  logic [IW-1:0]  num,
  input  logic           random,
  input  logic           req,
  output logic           ready,
  output logic           done,
  output logic           err,
  output logic           rand_mode,
  output logic [N*W-1:0] out
);

  localparam int unsigned KW = $clog2(N + 1);

  function automatic int unsigned fact(input int unsigned n);
    int unsigned f;
    f = 1;
    for (int unsigned i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  localparam int unsigned NFACT = fact(N);

  typedef enum logic [1:0] {CHOSE_BOARD, GAMING, GAME_INITIAL, WINNED} gstat_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  // element i holds piece a[i]
  typedef logic [N-1:0][W-1:0] board_t;

  function automatic board_t identity();
    board_t b;
    for (int unsigned i = 0; i < N; i++) b[i] = W'(i);
    return b;
  endfunction

  state_e        state_q, state_d;
  board_t        work_q, work_d;
  board_t        out_q;
  logic [KW-1:0] k_q;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          mode_q;
  logic          rand_mode_q;
  logic          done_q, err_q;

  logic          chose;
  logic          accept, reject;
  logic [W-1:0]  j;
  int unsigned   hi, lo;
  logic [W-1:0]  a_hi, a_lo;

  assign chose = (game_status == CHOSE_BOARD);

  // State register
  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; leaving CHOSE_BOARD aborts any run
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && !reject) state_d = S_RUN;
      S_RUN:   if (k_q == KW'(2)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!chose) state_d = S_IDLE;
  end

  // Handshake outputs and request decode
  always_comb begin
    ready  = (state_q == S_IDLE) && chose;
    accept = req && ready;
    reject = accept && !rand_mode_q && (32'(num) >= NFACT);
  end

  // Galois LFSR step, taps x^16+x^14+x^13+x^11+1
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ 16'hB400;
  end

  // Swap datapath: j from index digit or LFSR, then exchange a[k-1] and a[k-1-j]
  always_comb begin
    j     = '0;
    idx_d = idx_q;
    for (int unsigned d = 2; d <= N; d++) begin
      if (k_q == KW'(d)) begin
        if (mode_q) begin
          j = W'(32'(lfsr_q[7:0]) % d);
        end else begin
          j     = W'(32'(idx_q) % d);
          idx_d = IW'(32'(idx_q) / d);
        end
      end
    end
    hi   = 32'(k_q) - 1;
    lo   = hi - 32'(j);
    a_hi = '0;
    a_lo = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i == hi) a_hi = work_q[i];
      if (i == lo) a_lo = work_q[i];
    end
    work_d = work_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (i == hi)      work_d[i] = a_lo;
      else if (i == lo) work_d[i] = a_hi;
    end
  end

  // Datapath registers, mode toggle, LFSR and output pulses
  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= SEED;
      rand_mode_q <= 1'b0;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_q       <= identity();
      work_q      <= identity();
      k_q         <= '0;
      idx_q       <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (random) rand_mode_q <= ~rand_mode_q;
      if (!chose) begin
        out_q <= identity();
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              if (reject) begin
                err_q <= 1'b1;
              end else begin
                work_q <= identity();
                k_q    <= KW'(N);
                idx_q  <= num;
                mode_q <= rand_mode_q;
              end
            end
          end
          S_RUN: begin
            work_q <= work_d;
            idx_q  <= idx_d;
            k_q    <= k_q - KW'(1);
          end
          S_DONE: begin
            out_q  <= work_q;
            done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Flatten the board with a[0] in the MSBs
  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < N; i++) out[(N-1-i)*W +: W] = out_q[i];
  end

  assign done      = done_q;
  assign err       = err_q;
  assign rand_mode = rand_mode_q;

endmodule
